// File: rtl/sfft_stream_decoder.sv
// sfft_stream_decoder
//   Turns the stochastic bitstreams at the FFT butterfly outputs back into
//   binary. Over a window of 2^BITWIDTH qualified cycles it counts ones on
//   every real and imaginary lane. It then latches each count as a unipolar
//   count or a bipolar value (2*ones - 2^BITWIDTH) and holds the result under
//   a valid/ack handshake.
//
// Ports
//   iClk, iRst     clock (rising edge), asynchronous active-high reset
//   iStart         begin a window (in IDLE, or in DONE together with iAck)
//   iEn            sample qualifier; lane bits count only when high
//   iClr           synchronous abort to IDLE; clears counters and outputs
//   iAck           consumer acknowledges the held result
//   iReal, iImg    NUMINPUTS real / imaginary bitstreams
//   oReal, oImg    lane k at [k*W +: W], W = BITWIDTH+2
//   oValid         result held (DONE)
//   oBusy          window in progress (ACCUM)
module sfft_stream_decoder #(
    parameter int BITWIDTH  = 8,
    parameter int NUMINPUTS = 2,
    parameter int BIPOLAR   = 1
) (
    input  logic                              iClk,
    input  logic                              iRst,
    input  logic                              iStart,
    input  logic                              iEn,
    input  logic                              iClr,
    input  logic                              iAck,
    input  logic [NUMINPUTS-1:0]              iReal,
    input  logic [NUMINPUTS-1:0]              iImg,
    output logic [NUMINPUTS*(BITWIDTH+2)-1:0] oReal,
    output logic [NUMINPUTS*(BITWIDTH+2)-1:0] oImg,
    output logic                              oValid,
    output logic                              oBusy
);
    localparam int W  = BITWIDTH + 2;
    localparam int CW = BITWIDTH + 1;
    // Sample count of the last bit in a window (2^BITWIDTH - 1 already seen).
    localparam logic [CW-1:0] LAST = {1'b0, {BITWIDTH{1'b1}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                         state_q, state_d;
    logic [NUMINPUTS-1:0][CW-1:0]   re_cnt_q, re_cnt_d;
    logic [NUMINPUTS-1:0][CW-1:0]   im_cnt_q, im_cnt_d;
    logic [CW-1:0]                  smp_q, smp_d;
    logic [NUMINPUTS*W-1:0]         real_q, real_d;
    logic [NUMINPUTS*W-1:0]         img_q, img_d;

    // 2*ones fits unsigned in W bits; subtracting 2^BITWIDTH leaves a W-bit
    // two's complement value in -2^BITWIDTH..+2^BITWIDTH.
    function automatic logic [W-1:0] conv(input logic [CW-1:0] ones);
        if (BIPOLAR != 0) conv = {ones, 1'b0} - (W'(1) << BITWIDTH);
        else              conv = {1'b0, ones};
    endfunction

    always_comb begin
        state_d  = state_q;
        re_cnt_d = re_cnt_q;
        im_cnt_d = im_cnt_q;
        smp_d    = smp_q;
        real_d   = real_q;
        img_d    = img_q;
        if (iClr) begin
            state_d  = S_IDLE;
            re_cnt_d = '0;
            im_cnt_d = '0;
            smp_d    = '0;
            real_d   = '0;
            img_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: if (iStart) state_d = S_ACCUM;
                S_ACCUM: if (iEn) begin
                    for (int k = 0; k < NUMINPUTS; k++) begin
                        re_cnt_d[k] = re_cnt_q[k] + CW'(iReal[k]);
                        im_cnt_d[k] = im_cnt_q[k] + CW'(iImg[k]);
                    end
                    smp_d = smp_q + 1'b1;
                    if (smp_q == LAST) begin
                        // Final sample is already folded into *_cnt_d.
                        for (int k = 0; k < NUMINPUTS; k++) begin
                            real_d[k*W +: W] = conv(re_cnt_d[k]);
                            img_d[k*W +: W]  = conv(im_cnt_d[k]);
                        end
                        // Counters are left at zero so the next window
                        // (including a back-to-back restart) starts clean.
                        re_cnt_d = '0;
                        im_cnt_d = '0;
                        smp_d    = '0;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: if (iAck) state_d = iStart ? S_ACCUM : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= S_IDLE;
            re_cnt_q <= '0;
            im_cnt_q <= '0;
            smp_q    <= '0;
            real_q   <= '0;
            img_q    <= '0;
        end else begin
            state_q  <= state_d;
            re_cnt_q <= re_cnt_d;
            im_cnt_q <= im_cnt_d;
            smp_q    <= smp_d;
            real_q   <= real_d;
            img_q    <= img_d;
        end
    end

    // All outputs decode straight from registers.
    assign oReal  = real_q;
    assign oImg   = img_q;
    assign oValid = (state_q == S_DONE);
    assign oBusy  = (state_q == S_ACCUM);
endmodule

// File: tb/tb_sfft_stream_decoder.sv
module tb_sfft_stream_decoder;
    localparam int BW = 4;
    localparam int NI = 2;
    localparam int W  = BW + 2;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, en = 1'b0, clr = 1'b0, ack = 1'b0;
    logic [NI-1:0] re = '0, im = '0;
    logic [NI*W-1:0] ob_r, ob_i, ou_r, ou_i;
    logic vb, bb, vu, bu;

    always #5 clk = ~clk;

    sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI), .BIPOLAR(1)) dut_b (
        .iClk(clk), .iRst(rst), .iStart(start), .iEn(en), .iClr(clr), .iAck(ack),
        .iReal(re), .iImg(im), .oReal(ob_r), .oImg(ob_i), .oValid(vb), .oBusy(bb));

    sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI), .BIPOLAR(0)) dut_u (
        .iClk(clk), .iRst(rst), .iStart(start), .iEn(en), .iClr(clr), .iAck(ack),
        .iReal(re), .iImg(im), .oReal(ou_r), .oImg(ou_i), .oValid(vu), .oBusy(bu));

    int ncmp = 0, nfail = 0;

    typedef struct {
        logic [NI*W-1:0] rb, ib, ru, iu;
    } exp_t;
    exp_t sbq[$];
    exp_t last;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic v, input logic b);
        chk({tag, " valid_b"}, 64'(vb), 64'(v));
        chk({tag, " busy_b"},  64'(bb), 64'(b));
        chk({tag, " valid_u"}, 64'(vu), 64'(v));
        chk({tag, " busy_u"},  64'(bu), 64'(b));
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, " real_b"}, 64'(ob_r), 64'(e.rb));
        chk({tag, " img_b"},  64'(ob_i), 64'(e.ib));
        chk({tag, " real_u"}, 64'(ou_r), 64'(e.ru));
        chk({tag, " img_u"},  64'(ou_i), 64'(e.iu));
    endtask

    function automatic logic [W-1:0] lane(input int ones, input bit bip);
        if (bip) return W'(2 * ones - (1 << BW));
        return W'(ones);
    endfunction

    task automatic start_idle;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk_status("start", 1'b0, 1'b1);
    endtask

    task automatic restart;
        ack = 1'b1;
        start = 1'b1;
        tick;
        ack = 1'b0;
        start = 1'b0;
        chk_status("b2b", 1'b0, 1'b1);
    endtask

    // One full window; g[j] inserts an iEn=0 cycle (lanes all 1) before sample j.
    task automatic feed(input logic [15:0] r0, r1, i0, i1, g, input string tag);
        exp_t e, got;
        int c_r0, c_r1, c_i0, c_i1;
        c_r0 = $countones(r0); c_r1 = $countones(r1);
        c_i0 = $countones(i0); c_i1 = $countones(i1);
        e.rb = {lane(c_r1, 1'b1), lane(c_r0, 1'b1)};
        e.ib = {lane(c_i1, 1'b1), lane(c_i0, 1'b1)};
        e.ru = {lane(c_r1, 1'b0), lane(c_r0, 1'b0)};
        e.iu = {lane(c_i1, 1'b0), lane(c_i0, 1'b0)};
        sbq.push_back(e);
        for (int j = 0; j < 16; j++) begin
            if (g[j]) begin
                en = 1'b0; re = '1; im = '1;
                tick;
                chk_status({tag, " gap"}, 1'b0, 1'b1);
            end
            en = 1'b1;
            re = {r1[j], r0[j]};
            im = {i1[j], i0[j]};
            tick;
            if (j < 15) chk_status({tag, " accum"}, 1'b0, 1'b1);
        end
        en = 1'b0; re = '0; im = '0;
        chk_status({tag, " done"}, 1'b1, 1'b0);
        chk({tag, " sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            chk_out(tag, got);
            last = got;
        end
    endtask

    initial begin
        exp_t zero;
        zero.rb = '0; zero.ib = '0; zero.ru = '0; zero.iu = '0;

        // Reset state
        #2;
        chk_status("reset", 1'b0, 1'b0);
        chk_out("reset", zero);
        #10 rst = 1'b0;
        tick;

        // Asynchronous reset in the middle of a window
        start_idle;
        en = 1'b1; re = 2'b11; im = 2'b01;
        repeat (5) tick;
        #2 rst = 1'b1;
        #1;
        chk_status("async_rst", 1'b0, 1'b0);
        chk_out("async_rst", zero);
        #1 rst = 1'b0;
        repeat (3) tick;
        chk_status("post_rst_idle", 1'b0, 1'b0);
        chk_out("post_rst_idle", zero);
        en = 1'b0; re = '0; im = '0;

        // Known-count window, both modes
        start_idle;
        feed(16'hFFFF, 16'h0000, 16'h5555, 16'h0FFF, 16'h0000, "known");

        // Hold in DONE with iAck low; iStart pulse is ignored
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick;
            chk_status("hold", 1'b1, 1'b0);
            chk_out("hold", last);
        end
        start = 1'b0;

        // Back-to-back restart, same stimulus with 5 iEn gaps
        restart;
        feed(16'hFFFF, 16'h0000, 16'h5555, 16'h0FFF, 16'h4922, "gaps");

        // Ack alone returns to IDLE, outputs held
        ack = 1'b1;
        tick;
        ack = 1'b0;
        chk_status("ack_idle", 1'b0, 1'b0);
        chk_out("ack_idle", last);

        // Abort after 7 samples
        start_idle;
        en = 1'b1; re = 2'b11; im = 2'b11;
        repeat (7) tick;
        en = 1'b0; clr = 1'b1;
        tick;
        clr = 1'b0;
        chk_status("abort", 1'b0, 1'b0);
        chk_out("abort", zero);
        repeat (3) tick;
        chk_status("abort_idle", 1'b0, 1'b0);

        // Fresh window after abort: no carry-over
        start_idle;
        feed(16'h00FF, 16'hF0F0, 16'h0001, 16'hFFFE, 16'h0000, "fresh");

        // Randomized windows, back to back
        for (int w = 0; w < 50; w++) begin
            restart;
            feed(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                 16'($urandom & $urandom & $urandom), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
